cvxif_coproc_responder: RTL
===========================

Name: cvxif_coproc_responder

Overview:
- Coprocessor-side responder for the CV-X-IF extension interface; the core is the initiator.
- Decodes custom-3 opcode instructions (opcode 7'b1111011) offered on the issue channel and accepts or rejects them in the same cycle.
- Queues accepted instructions until the core commits or kills them, executes the survivors with a fixed latency, and returns results on a valid/ready result channel.
- Sits beside the integer pipeline at the top level, next to the core's CV-X-IF port.

Parameters:
XLEN, 32, operand/result width
ID_W, 4, instruction-ID width (must cover NrScoreboardEntries)
DEPTH, 4, queue entries, power of two, >=2
LATENCY, 2, execute cycles per instruction, >=1

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
issue_valid_i  in  1  issue request valid
issue_ready_o  out  1  issue handshake ready
issue_instr_i  in  32  instruction word
issue_id_i  in  ID_W  instruction ID
issue_rs1_i  in  XLEN  rs1 value
issue_rs2_i  in  XLEN  rs2 value
issue_rs_valid_i  in  2  operand-valid flags {rs2,rs1}
issue_accept_o  out  1  instruction is ours (valid with the handshake)
issue_writeback_o  out  1  instruction writes rd
commit_valid_i  in  1  commit/kill message valid
commit_id_i  in  ID_W  ID being committed/killed
commit_kill_i  in  1  1 = kill, 0 = commit
result_valid_o  out  1  result valid
result_ready_i  in  1  core accepts result
result_id_o  out  ID_W  ID of result
result_data_o  out  XLEN  result value
result_rd_o  out  5  destination register
result_we_o  out  1  write enable
result_exc_o  out  1  exception flag (feature only; else tied 0)

Behaviour:
- Clock and reset: one clock clk_i; reset rst_i is asynchronous and active-high.
- Reset:
  - Queue empty, FSM in IDLE, latency counter 0.
  - All outputs 0, except issue_ready_o = 1.
- Issue decode (combinational):
  - ours = opcode==7'b1111011 && funct7==0 && funct3 in {0:ADD, 1:SUB, 2:XOR, 3:NOP}.
  - issue_ready_o = !full && (!ours || (funct3==3 || &issue_rs_valid_i)).
  - issue_accept_o = ours.
  - issue_writeback_o = ours && funct3!=3.
- Enqueue: an entry is written on issue_valid_i && issue_ready_o && ours, in the same cycle.
  - Entry stores {id, funct3, rd, rs1, rs2, committed=0}.
  - Non-ours handshakes are not queued.
- Commit: on commit_valid_i, search every valid entry for a matching id.
  - commit_kill_i=1: the entry is invalidated.
  - commit_kill_i=0: committed<=1.
  - No match: ignored.
  - A commit arriving in the same cycle as the issue of that ID applies to the new entry.
- Queue: a circular buffer with head and tail pointers wrapping modulo DEPTH.
  - full when count==DEPTH; issue_ready_o is 0 when full.
  - Invalidated entries at the head are popped 1 per cycle in IDLE.
- FSM states:
  - IDLE: head valid && committed -> EXEC, counter <= LATENCY-1.
  - EXEC: counter decrements each cycle; at 0 the result register is loaded -> RESP.
  - RESP: result_valid_o=1 and outputs held stable; on result_ready_i, pop head -> IDLE.
  - Back-to-back results are therefore LATENCY+1 cycles apart minimum.
  - Commit-to-result latency is LATENCY+1 cycles when IDLE.
- Execute arithmetic:
  - ADD/SUB/XOR operate modulo 2^XLEN, with no overflow flag.
  - NOP produces data 0 and result_we_o=0, but is still reported.
- Kill of the entry already in EXEC/RESP is ignored; the core never kills a committed ID.
- Simultaneous enqueue and pop in one cycle: count is unchanged.
- Reset asserted mid-operation: state is flushed immediately and no result is emitted.

Optional Feature:
- Macro: CVXIF_COPROC_EXC_EN.
- Defined:
  - funct3==7 is also ours, with writeback 0.
  - It executes normally; its result has result_exc_o=1, result_we_o=0, result_data_o=0.
- Undefined:
  - funct3==7 is not accepted (issue_accept_o=0).
  - result_exc_o is constant 0.

Test Plan:
1. ADD x5, rs1=0xFFFF_FFFF, rs2=2, id=3; commit id 3 one cycle later -> issue_accept_o=1, issue_writeback_o=1; result valid LATENCY+1 cycles after commit with id=3, rd=5, data=0x1, we=1.
2. Opcode 7'b0110011 offered -> handshake completes with issue_accept_o=0, nothing queued, no result ever produced.
3. Issue ids 0..3 with result_ready_i=0 and no commits -> 5th issue sees issue_ready_o=0; after killing id 0 and committing ids 1..3, ready returns and results arrive with ids 1,2,3 in order.
4. SUB with issue_rs_valid_i=2'b01 -> issue_ready_o=0 until the flags reach 2'b11; then accept, result = rs1-rs2.
5. Result held with result_ready_i=0 for 5 cycles -> id, data and rd stay stable; rst_i pulsed in RESP -> result_valid_o drops asynchronously and the queue is empty afterwards.
6. With CVXIF_COPROC_EXC_EN: funct3=7, id=2, committed -> result_exc_o=1, we=0, data=0. Without the macro: issue_accept_o=0.

Source files
------------

// File: rtl/cvxif_coproc_responder.sv
// CV-X-IF coprocessor responder: custom-3 ADD/SUB/XOR/NOP with commit queue.
// Define CVXIF_COPROC_EXC_EN to also accept funct3=7 as an exception op.
module cvxif_coproc_responder #(
  parameter int XLEN    = 32,
  parameter int ID_W    = 4,
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            issue_valid_i,
  output logic            issue_ready_o,
  input  logic [31:0]     issue_instr_i,
  input  logic [ID_W-1:0] issue_id_i,
  input  logic [XLEN-1:0] issue_rs1_i,
  input  logic [XLEN-1:0] issue_rs2_i,
  input  logic [1:0]      issue_rs_valid_i,
  output logic            issue_accept_o,
  output logic            issue_writeback_o,
  input  logic            commit_valid_i,
  input  logic [ID_W-1:0] commit_id_i,
  input  logic            commit_kill_i,
  output logic            result_valid_o,
  input  logic            result_ready_i,
  output logic [ID_W-1:0] result_id_o,
  output logic [XLEN-1:0] result_data_o,
  output logic [4:0]      result_rd_o,
  output logic            result_we_o,
  output logic            result_exc_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [6:0] OPC = 7'b1111011;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t state, state_n;

  logic [PW-1:0]   head, tail;
  logic [PW:0]     count;
  logic [CW-1:0]   cnt;
  logic [DEPTH-1:0] q_valid, q_comm;
  logic [ID_W-1:0] q_id  [DEPTH];
  logic [2:0]      q_f3  [DEPTH];
  logic [4:0]      q_rd  [DEPTH];
  logic [XLEN-1:0] q_rs1 [DEPTH];
  logic [XLEN-1:0] q_rs2 [DEPTH];

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rd;
  logic       f3_ok, ours, full;
  logic       push, pop, pop_dead, pop_done;
  logic       start, done, busy_head;
  logic       new_hit, unused;

  logic [XLEN-1:0] res_data;
  logic            res_we, res_exc;

  assign opcode = issue_instr_i[6:0];
  assign rd     = issue_instr_i[11:7];
  assign funct3 = issue_instr_i[14:12];
  assign funct7 = issue_instr_i[31:25];
  assign unused = ^issue_instr_i[24:15];

`ifdef CVXIF_COPROC_EXC_EN
  assign f3_ok = (funct3 <= 3'd3) || (funct3 == 3'd7);
`else
  assign f3_ok = funct3 <= 3'd3;
`endif

  assign ours = (opcode == OPC) && (funct7 == 7'd0) && f3_ok;
  assign full = count == (PW+1)'(DEPTH);

  assign issue_ready_o =
    !full && (!ours || funct3 == 3'd3 || &issue_rs_valid_i);
  assign issue_accept_o    = ours;
  assign issue_writeback_o = ours && funct3 != 3'd3 && funct3 != 3'd7;

  assign push     = issue_valid_i && issue_ready_o && ours;
  assign pop_dead = state == IDLE && count != '0 && !q_valid[head];
  assign pop_done = state == RESP && result_ready_i;
  assign pop      = pop_dead || pop_done;

  assign start     = state == IDLE && q_valid[head] && q_comm[head];
  assign done      = state == EXEC && cnt == '0;
  assign busy_head = state != IDLE;
  assign new_hit   = commit_valid_i && commit_id_i == issue_id_i;

  assign result_valid_o = state == RESP;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start)          state_n = EXEC;
      EXEC:    if (done)           state_n = RESP;
      RESP:    if (result_ready_i) state_n = IDLE;
      default:                     state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt <= '0;
    else if (start) cnt <= CW'(LATENCY - 1);
    else if (state == EXEC && cnt != '0) cnt <= cnt - CW'(1);
  end

  // The head entry is protected from kills once it has left IDLE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      q_valid <= '0;
      q_comm  <= '0;
    end else begin
      if (commit_valid_i) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (q_valid[i] && q_id[i] == commit_id_i &&
              !(busy_head && PW'(i) == head)) begin
            if (commit_kill_i) q_valid[i] <= 1'b0;
            else               q_comm[i]  <= 1'b1;
          end
        end
      end
      if (pop) begin
        q_valid[head] <= 1'b0;
        head          <= head + PW'(1);
      end
      if (push) begin
        q_valid[tail] <= !(new_hit && commit_kill_i);
        q_comm[tail]  <= new_hit && !commit_kill_i;
        tail          <= tail + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      q_id[tail]  <= issue_id_i;
      q_f3[tail]  <= funct3;
      q_rd[tail]  <= rd;
      q_rs1[tail] <= issue_rs1_i;
      q_rs2[tail] <= issue_rs2_i;
    end
  end

  always_comb begin
    res_data = '0;
    res_we   = 1'b0;
    res_exc  = 1'b0;
    unique case (q_f3[head])
      3'd0: begin
        res_data = q_rs1[head] + q_rs2[head];
        res_we   = 1'b1;
      end
      3'd1: begin
        res_data = q_rs1[head] - q_rs2[head];
        res_we   = 1'b1;
      end
      3'd2: begin
        res_data = q_rs1[head] ^ q_rs2[head];
        res_we   = 1'b1;
      end
`ifdef CVXIF_COPROC_EXC_EN
      3'd7:    res_exc = 1'b1;
`endif
      default: ;
    endcase
  end

`ifdef CVXIF_COPROC_EXC_EN
  logic exc_q;
  assign result_exc_o = exc_q;
`else
  assign result_exc_o = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      result_id_o   <= '0;
      result_data_o <= '0;
      result_rd_o   <= '0;
      result_we_o   <= 1'b0;
`ifdef CVXIF_COPROC_EXC_EN
      exc_q         <= 1'b0;
`endif
    end else if (done) begin
      result_id_o   <= q_id[head];
      result_data_o <= res_data;
      result_rd_o   <= q_rd[head];
      result_we_o   <= res_we;
`ifdef CVXIF_COPROC_EXC_EN
      exc_q         <= res_exc;
`endif
    end
  end

endmodule
